// File: rtl/cache_pkg.sv
// Shared types and parameter helpers for the direct-mapped cache controller.
// Provides the fill FSM state enum, default parameter values and the
// address-field width derivations (offset, index, tag).
package cache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_LINE_WORDS = 8;
   localparam int DEF_SETS       = 64;
   localparam int DEF_MEM_LAT    = 4;

   // Word-offset bits within a line (byte bit 0 is not part of the offset).
   function automatic int calc_off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int calc_idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // Whatever is left above offset, index and the ignored byte bit.
   function automatic int calc_tag_w(input int addr_w, input int line_words, input int sets);
      return addr_w - 1 - calc_off_w(line_words) - calc_idx_w(sets);
   endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Bundle of the pipeline request/response port and the backing-memory port.
// Ports: req_valid/req_wr/req_addr/req_wdata -> rsp_rdata/stall (pipeline side),
//        mem_en/mem_wr/mem_addr/mem_wdata -> mem_rdata/mem_rvalid (memory side).
interface dm_cache_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] rsp_rdata;
   logic              stall;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;

   // Environment view: pipeline requester plus backing memory.
   modport master (
      output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
      input  rsp_rdata, stall, mem_en, mem_wr, mem_addr, mem_wdata
   );

   // Cache controller view.
   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
      output rsp_rdata, stall, mem_en, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dm_cache_fill_fsm.sv
// Line-fill controller: IDLE/FILL state, issue and return counters, memory strobes.
// Ports: request fields + hit in; stall, fill write strobes/counters and the
//        backing-memory command (write-through in IDLE, line reads in FILL) out.
module dm_cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   localparam int OFF_W     = calc_off_w(LINE_WORDS),
   localparam int LINE_W    = ADDR_W - 1 - OFF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              hit,
   input  logic              mem_rvalid,
   output logic              stall,
   output logic              busy,
   output logic              miss_start,
   output logic              fill_we,
   output logic              fill_done,
   output logic [OFF_W-1:0]  ret_cnt,
   output logic [LINE_W-1:0] fill_line,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata
);

   // issue counter carries one extra bit so "all words issued" is representable
   localparam logic [OFF_W:0]   ISSUE_END = (OFF_W+1)'(LINE_WORDS);
   localparam logic [OFF_W-1:0] RET_LAST  = OFF_W'(LINE_WORDS - 1);

   fill_state_t       state_q, state_d;
   logic [OFF_W:0]    issue_cnt_q;
   logic [OFF_W-1:0]  ret_cnt_q;
   logic [LINE_W-1:0] line_q;
   logic              issuing;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         line_q      <= '0;
      end else begin
         state_q <= state_d;
         if (miss_start) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            // line address is latched so the fill does not depend on the
            // requester keeping req_addr stable
            line_q      <= req_addr[ADDR_W-1:OFF_W+1];
         end else begin
            if (issuing) issue_cnt_q <= issue_cnt_q + 1'b1;
            if (fill_we) ret_cnt_q   <= ret_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      miss_start = 1'b0;
      issuing    = 1'b0;
      fill_we    = 1'b0;
      fill_done  = 1'b0;
      mem_en     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_wr) begin
                  // write-through, hit or miss, never stalls
                  mem_en    = 1'b1;
                  mem_wr    = 1'b1;
                  mem_addr  = req_addr;
                  mem_wdata = req_wdata;
               end else if (!hit) begin
                  stall      = 1'b1;
                  miss_start = 1'b1;
                  state_d    = FILL;
               end
            end
         end
         FILL: begin
            stall   = 1'b1;
            issuing = (issue_cnt_q != ISSUE_END);
            if (issuing) begin
               mem_en   = 1'b1;
               mem_addr = {line_q, issue_cnt_q[OFF_W-1:0], 1'b0};
            end
            // returns overlap with issue; fixed latency keeps them in order
            fill_we = mem_rvalid;
            if (mem_rvalid && (ret_cnt_q == RET_LAST)) begin
               fill_done = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q == FILL);
   assign ret_cnt   = ret_cnt_q;
   assign fill_line = line_q;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache with line fill.
// Ports: clk, rst (sync, active high), bus (dm_cache_ctrl_if.slave: pipeline
//        request/response and backing memory); optional DM_CACHE_STATS_EN adds
//        stat_hits / stat_misses (32-bit, wrapping).
module dm_cache_ctrl
   import cache_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int SETS       = DEF_SETS,
   parameter int MEM_LAT    = DEF_MEM_LAT
) (
   input  logic clk,
   input  logic rst,
   dm_cache_ctrl_if.slave bus
`ifdef DM_CACHE_STATS_EN
   ,
   output logic [31:0] stat_hits,
   output logic [31:0] stat_misses
`endif
);

   localparam int OFF_W  = calc_off_w(LINE_WORDS);
   localparam int IDX_W  = calc_idx_w(SETS);
   localparam int TAG_W  = calc_tag_w(ADDR_W, LINE_WORDS, SETS);
   localparam int LINE_W = ADDR_W - 1 - OFF_W;

   if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line_words
      $error("LINE_WORDS must be a power of 2 and at least 2");
   end
   if ((SETS & (SETS - 1)) != 0) begin : g_bad_sets
      $error("SETS must be a power of 2");
   end
   if (MEM_LAT < 1) begin : g_bad_mem_lat
      $error("MEM_LAT must be at least 1");
   end

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];

   logic [OFF_W-1:0]  req_off;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic              hit;
   logic              hit_wr;

   logic              stall;
   logic              busy;
   logic              miss_start;
   logic              fill_we;
   logic              fill_done;
   logic [OFF_W-1:0]  ret_cnt;
   logic [LINE_W-1:0] fill_line;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;

   assign req_off  = bus.req_addr[OFF_W:1];
   assign req_idx  = bus.req_addr[OFF_W+IDX_W:OFF_W+1];
   assign req_tag  = bus.req_addr[ADDR_W-1:OFF_W+IDX_W+1];
   assign fill_idx = fill_line[IDX_W-1:0];
   assign fill_tag = fill_line[LINE_W-1:IDX_W];

   assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign hit_wr = bus.req_valid && bus.req_wr && hit && !busy;

   dm_cache_fill_fsm #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS)
   ) u_fill_fsm (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (bus.req_valid),
      .req_wr     (bus.req_wr),
      .req_addr   (bus.req_addr),
      .req_wdata  (bus.req_wdata),
      .hit        (hit),
      .mem_rvalid (bus.mem_rvalid),
      .stall      (stall),
      .busy       (busy),
      .miss_start (miss_start),
      .fill_we    (fill_we),
      .fill_done  (fill_done),
      .ret_cnt    (ret_cnt),
      .fill_line  (fill_line),
      .mem_en     (bus.mem_en),
      .mem_wr     (bus.mem_wr),
      .mem_addr   (bus.mem_addr),
      .mem_wdata  (bus.mem_wdata)
   );

   // Only valid bits need reset; stale tags and data are masked by valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (fill_done) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_done) tag_q[fill_idx] <= fill_tag;
   end

   // Fill returns and write hits are mutually exclusive (writes stall-free only in IDLE).
   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_q[fill_idx][ret_cnt] <= bus.mem_rdata;
      end else if (hit_wr) begin
         data_q[req_idx][req_off] <= bus.req_wdata;
      end
   end

   assign bus.rsp_rdata = data_q[req_idx][req_off];
   assign bus.stall     = stall;

`ifdef DM_CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else begin
         if (bus.req_valid && !bus.req_wr && hit && !busy) stat_hits <= stat_hits + 32'd1;
         if (miss_start) stat_misses <= stat_misses + 32'd1;
      end
   end
`endif

endmodule
